// File: rtl/key_buffer_fifo.sv
// ============================================================================
// Module   : key_buffer_fifo
// Purpose  : Keypoint holding FIFO between FAST/orientation (push side) and
//            the BRIEF descriptor unit (pop side). Circular-pointer store with
//            occupancy/status outputs, selectable overflow policy, saturating
//            drop counter and synchronous per-frame flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_buffer_fifo #(
  parameter int DEPTH    = 100,
  parameter int COOR_W   = 10,
  parameter int TRIG_W   = 12,
  parameter int SCORE_W  = 8,
  parameter int OVF_MODE = 0,
  parameter int DROP_W   = 16
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_clear,
  input  logic                           i_flag,
  input  logic                           i_hit,
  input  logic [TRIG_W-1:0]              i_sin,
  input  logic [TRIG_W-1:0]              i_cos,
  input  logic [COOR_W-1:0]              i_coor_x,
  input  logic [COOR_W-1:0]              i_coor_y,
  input  logic [SCORE_W-1:0]             i_score,
  output logic                           o_valid,
  output logic [TRIG_W-1:0]              o_sin,
  output logic [TRIG_W-1:0]              o_cos,
  output logic [COOR_W-1:0]              o_coor_x,
  output logic [COOR_W-1:0]              o_coor_y,
  output logic [SCORE_W-1:0]             o_score,
  output logic [$clog2(DEPTH+1)-1:0]     o_count,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [DROP_W-1:0]              o_drop_cnt
);

  // Geometry of the store and its bookkeeping registers.
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 2 * TRIG_W + 2 * COOR_W + SCORE_W;

  localparam logic [PTR_W-1:0]  C_LAST_PTR    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  C_DEPTH_CNT   = CNT_W'(DEPTH);
  localparam logic [DROP_W-1:0] C_DROP_MAX    = {DROP_W{1'b1}};
  localparam bit                C_DROP_OLDEST = (OVF_MODE == 1);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [DROP_W-1:0]  r_drop_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf;
  logic               w_write;
  logic               w_adv_rd;
  logic [ENTRY_W-1:0] w_wr_entry;
  logic [ENTRY_W-1:0] w_head;

  // Wrap-aware pointer increment; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full  = (r_cnt == C_DEPTH_CNT);
  assign w_empty = (r_cnt == '0);

  // Flush overrides everything; a pop on an empty buffer is silently ignored.
  assign w_pop   = i_hit && !w_empty && !i_clear;
  // A push is accepted when there is room, or when a pop frees the slot in
  // the same cycle (full + push + pop keeps the buffer full with no drop).
  assign w_push  = i_flag && !i_clear && (!w_full || w_pop);
  // Overflow: push into a full buffer with no simultaneous pop.
  assign w_ovf   = i_flag && !i_clear && w_full && !w_pop;

  // In drop-oldest mode the overflowing entry overwrites the head slot
  // (wr_ptr == rd_ptr when full) and both pointers advance together.
  assign w_write  = w_push || (w_ovf && C_DROP_OLDEST);
  assign w_adv_rd = w_pop  || (w_ovf && C_DROP_OLDEST);

  assign w_wr_entry = {i_sin, i_cos, i_coor_x, i_coor_y, i_score};

  // Entry storage; contents need no reset because the head is masked by valid.
  always_ff @(posedge i_clk) begin
    if (w_write) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_write) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_adv_rd) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // Saturating count of keypoints lost to overflow, cleared per frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= '0;
    end else if (i_clear) begin
      r_drop_cnt <= '0;
    end else if (w_ovf && (r_drop_cnt != C_DROP_MAX)) begin
      r_drop_cnt <= r_drop_cnt + DROP_W'(1);
    end
  end

  // Head entry and status are derived purely from registered state.
  assign w_head     = r_mem[r_rd_ptr];
  assign o_valid    = !w_empty;
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_count    = r_cnt;
  assign o_drop_cnt = r_drop_cnt;

  assign {o_sin, o_cos, o_coor_x, o_coor_y, o_score} =
      o_valid ? w_head : '0;

endmodule

`default_nettype wire

// File: tb/tb_key_buffer_fifo.sv
// ============================================================================
// Module   : tb_key_buffer_fifo
// Purpose  : Scoreboard bench for key_buffer_fifo. Three instances:
//            0: DEPTH=4 drop-new, DROP_W=3; 1: DEPTH=4 drop-oldest;
//            2: DEPTH=5 drop-new (reset and wrap-around).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_buffer_fifo;

  localparam int EW = 52;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic flag [3];
  logic hit  [3];
  logic clr  [3];
  logic [11:0] d_sin, d_cos;
  logic [9:0]  d_x, d_y;
  logic [7:0]  d_score;

  logic        valid [3];
  logic        full  [3];
  logic        empty [3];
  logic [2:0]  cnt   [3];
  logic [15:0] drop  [3];
  logic [11:0] s_o   [3];
  logic [11:0] c_o   [3];
  logic [9:0]  x_o   [3];
  logic [9:0]  y_o   [3];
  logic [7:0]  sc_o  [3];
  logic [EW-1:0] head [3];
  logic [2:0]  drop_a;
  logic [15:0] drop_b, drop_c;

  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  logic [EW-1:0] q2[$];

  int n_vec = 0;
  int n_bad = 0;

  key_buffer_fifo #(.DEPTH(4), .OVF_MODE(0), .DROP_W(3)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr[0]), .i_flag(flag[0]), .i_hit(hit[0]),
    .i_sin(d_sin), .i_cos(d_cos), .i_coor_x(d_x), .i_coor_y(d_y), .i_score(d_score),
    .o_valid(valid[0]), .o_sin(s_o[0]), .o_cos(c_o[0]), .o_coor_x(x_o[0]),
    .o_coor_y(y_o[0]), .o_score(sc_o[0]), .o_count(cnt[0]), .o_full(full[0]),
    .o_empty(empty[0]), .o_drop_cnt(drop_a));

  key_buffer_fifo #(.DEPTH(4), .OVF_MODE(1), .DROP_W(16)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr[1]), .i_flag(flag[1]), .i_hit(hit[1]),
    .i_sin(d_sin), .i_cos(d_cos), .i_coor_x(d_x), .i_coor_y(d_y), .i_score(d_score),
    .o_valid(valid[1]), .o_sin(s_o[1]), .o_cos(c_o[1]), .o_coor_x(x_o[1]),
    .o_coor_y(y_o[1]), .o_score(sc_o[1]), .o_count(cnt[1]), .o_full(full[1]),
    .o_empty(empty[1]), .o_drop_cnt(drop_b));

  key_buffer_fifo #(.DEPTH(5), .OVF_MODE(0), .DROP_W(16)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clr[2]), .i_flag(flag[2]), .i_hit(hit[2]),
    .i_sin(d_sin), .i_cos(d_cos), .i_coor_x(d_x), .i_coor_y(d_y), .i_score(d_score),
    .o_valid(valid[2]), .o_sin(s_o[2]), .o_cos(c_o[2]), .o_coor_x(x_o[2]),
    .o_coor_y(y_o[2]), .o_score(sc_o[2]), .o_count(cnt[2]), .o_full(full[2]),
    .o_empty(empty[2]), .o_drop_cnt(drop_c));

  assign drop[0] = {13'd0, drop_a};
  assign drop[1] = drop_b;
  assign drop[2] = drop_c;

  for (genvar g = 0; g < 3; g++) begin : g_head
    assign head[g] = {s_o[g], c_o[g], x_o[g], y_o[g], sc_o[g]};
  end

  // Deterministic entry built from a key value x.
  function automatic logic [EW-1:0] mk(input int x);
    return {12'(x * 3 + 1), 12'(x * 5 + 2), 10'(x), 10'(x + 100), 8'(x ^ 'h5a)};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Pop the expected head for instance k and compare with what the DUT shows.
  task automatic pop_cmp(input int k);
    logic [EW-1:0] e;
    bit have;
    have = 1'b0;
    e = '0;
    case (k)
      0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; end
      1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
      default: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_vec++;
      n_bad++;
      $display("FAIL pop_unexpected inst%0d: got %0h want no entry", k, head[k]);
    end else begin
      check($sformatf("pop_head inst%0d", k), 64'(head[k]), 64'(e));
    end
  endtask

  // Monitor: whenever the consumer takes the head, score it against the queue.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst_n && hit[k] && !clr[k]) begin
        if (valid[k]) pop_cmp(k);
        else check($sformatf("underflow_head inst%0d", k), 64'(head[k]), 64'd0);
      end
    end
  end

  task automatic zero_inputs();
    for (int i = 0; i < 3; i++) begin
      flag[i] = 1'b0; hit[i] = 1'b0; clr[i] = 1'b0;
    end
    {d_sin, d_cos, d_x, d_y, d_score} = '0;
  endtask

  task automatic drive(input int k, input bit f, input bit h, input bit c, input logic [EW-1:0] e);
    @(posedge clk); #1;
    zero_inputs();
    flag[k] = f; hit[k] = h; clr[k] = c;
    {d_sin, d_cos, d_x, d_y, d_score} = e;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    zero_inputs();
  endtask

  task automatic fill4(input int k);
    for (int x = 1; x <= 4; x++) begin
      drive(k, 1'b1, 1'b0, 1'b0, mk(x));
      if (k == 0) q0.push_back(mk(x)); else q1.push_back(mk(x));
    end
  endtask

  task automatic drain(input int k, input int n);
    for (int i = 0; i < n; i++) drive(k, 1'b0, 1'b1, 1'b0, '0);
    idle();
    check($sformatf("drained_empty inst%0d", k), 64'(empty[k]), 64'd1);
  endtask

  initial begin
    int occ;
    bit f, h, pop, push;
    logic [63:0] r;
    zero_inputs();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid inst%0d", k), 64'(valid[k]), 64'd0);
      check($sformatf("rst_empty inst%0d", k), 64'(empty[k]), 64'd1);
      check($sformatf("rst_full inst%0d", k), 64'(full[k]), 64'd0);
      check($sformatf("rst_count inst%0d", k), 64'(cnt[k]), 64'd0);
      check($sformatf("rst_drop inst%0d", k), 64'(drop[k]), 64'd0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Reset mid-stream with 5 entries held in instance 2.
    for (int x = 1; x <= 5; x++) begin
      drive(2, 1'b1, 1'b0, 1'b0, mk(x));
      q2.push_back(mk(x));
    end
    idle();
    check("c_full_before_rst", 64'(full[2]), 64'd1);
    check("c_count_before_rst", 64'(cnt[2]), 64'd5);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    check("c_async_valid", 64'(valid[2]), 64'd0);
    check("c_async_count", 64'(cnt[2]), 64'd0);
    check("c_async_head", 64'(head[2]), 64'd0);
    check("c_async_empty", 64'(empty[2]), 64'd1);
    check("c_async_full", 64'(full[2]), 64'd0);
    q2.delete();
    @(negedge clk) rst_n = 1'b1;
    drive(2, 1'b0, 1'b1, 1'b0, '0);
    idle();
    check("c_hit_idle_count", 64'(cnt[2]), 64'd0);

    // Fill and drain, instance 0.
    fill4(0);
    idle();
    check("a_fill_full", 64'(full[0]), 64'd1);
    check("a_fill_count", 64'(cnt[0]), 64'd4);
    check("a_fill_head_x", 64'(x_o[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 1'b1, 1'b0, '0);
      idle();
      if (i < 3) check($sformatf("a_drain_head_x%0d", i), 64'(x_o[0]), 64'(i + 2));
    end
    check("a_drain_valid", 64'(valid[0]), 64'd0);
    check("a_drain_head_zero", 64'(head[0]), 64'd0);

    // Overflow, drop-new.
    fill4(0);
    drive(0, 1'b1, 1'b0, 1'b0, mk(5));
    idle();
    check("a_ovf_drop", 64'(drop[0]), 64'd1);
    check("a_ovf_count", 64'(cnt[0]), 64'd4);
    check("a_ovf_head_x", 64'(x_o[0]), 64'd1);
    drain(0, 4);

    // Overflow, drop-oldest.
    fill4(1);
    drive(1, 1'b1, 1'b0, 1'b0, mk(5));
    void'(q1.pop_front());
    q1.push_back(mk(5));
    idle();
    check("b_ovf_drop", 64'(drop[1]), 64'd1);
    check("b_ovf_count", 64'(cnt[1]), 64'd4);
    check("b_ovf_head_x", 64'(x_o[1]), 64'd2);
    drain(1, 4);

    // Push+pop on full: no drop, order 2,3,4,9.
    fill4(0);
    drive(0, 1'b1, 1'b1, 1'b0, mk(9));
    q0.push_back(mk(9));
    idle();
    check("a_pp_full_count", 64'(cnt[0]), 64'd4);
    check("a_pp_full_drop", 64'(drop[0]), 64'd1);
    check("a_pp_full_head_x", 64'(x_o[0]), 64'd2);
    drain(0, 4);

    // Push+pop on empty.
    drive(1, 1'b1, 1'b1, 1'b0, mk(7));
    q1.push_back(mk(7));
    idle();
    check("b_pp_empty_count", 64'(cnt[1]), 64'd1);
    check("b_pp_empty_valid", 64'(valid[1]), 64'd1);
    check("b_pp_empty_head_x", 64'(x_o[1]), 64'd7);
    drain(1, 1);

    // Wrap-around on DEPTH=5 with random fields.
    occ = 0;
    for (int c = 0; c < 23; c++) begin
      f = (c < 12) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      h = 1'($urandom_range(0, 1));
      r = {$urandom(), $urandom()};
      pop  = h && (occ > 0);
      push = f && ((occ < 5) || pop);
      drive(2, f, h, 1'b0, r[EW-1:0]);
      check($sformatf("c_wrap_count%0d", c), 64'(cnt[2]), 64'(occ));
      if (cnt[2] > 3'd5) check("c_wrap_count_bound", 64'(cnt[2]), 64'd5);
      if (push) q2.push_back(r[EW-1:0]);
      occ = occ + int'(push) - int'(pop);
    end
    idle();
    check("c_wrap_final_count", 64'(cnt[2]), 64'(occ));
    drain(2, occ);
    check("c_wrap_queue_left", 64'(q2.size()), 64'd0);

    // Drop counter saturation (DROP_W=3) then flush with simultaneous push.
    fill4(0);
    for (int x = 20; x < 30; x++) drive(0, 1'b1, 1'b0, 1'b0, mk(x));
    idle();
    check("a_sat_drop", 64'(drop[0]), 64'd7);
    check("a_sat_head_x", 64'(x_o[0]), 64'd1);
    drive(0, 1'b1, 1'b0, 1'b1, mk(50));
    q0.delete();
    idle();
    check("a_clr_count", 64'(cnt[0]), 64'd0);
    check("a_clr_drop", 64'(drop[0]), 64'd0);
    check("a_clr_valid", 64'(valid[0]), 64'd0);
    check("a_clr_empty", 64'(empty[0]), 64'd1);
    check("a_clr_head", 64'(head[0]), 64'd0);
    drive(0, 1'b0, 1'b1, 1'b0, '0);
    idle();
    check("a_clr_after_hit_count", 64'(cnt[0]), 64'd0);

    check("queues_left", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
